// File: rtl/lc3b_types.sv
// Shared lc3b type definitions.
//   lc3b_word : 16-bit machine word / byte address
//   lc3b_line : 128-bit cache line, shared by the cache and physical memory ports
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

endpackage

// File: rtl/pmem_responder_if.sv
// Memory-side port between the L2 cache (master) and physical memory (slave).
//   pmem_read / pmem_write : request strobes driven by the master
//   pmem_address           : byte address of the line
//   pmem_wdata             : line to write
//   pmem_byte_enable       : carried for port compatibility, unused by memory
//   pmem_rdata             : line returned on a read response
//   pmem_resp              : one-cycle completion pulse from the slave
//
// Handshake: the master raises pmem_read or pmem_write (write wins if both) and
// holds it, with address and wdata stable, until it observes pmem_resp high on a
// rising edge; on that edge it must drop or change the request. Dropping the
// request before pmem_resp aborts it with no response and no storage change.
interface pmem_responder_if;
    import lc3b_types::*;

    logic       pmem_read;
    logic       pmem_write;
    lc3b_word   pmem_address;
    lc3b_line   pmem_wdata;
    logic [1:0] pmem_byte_enable;
    lc3b_line   pmem_rdata;
    logic       pmem_resp;

    modport master (
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        output pmem_byte_enable,
        input  pmem_rdata,
        input  pmem_resp
    );

    modport slave (
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        input  pmem_byte_enable,
        output pmem_rdata,
        output pmem_resp
    );

endinterface

// File: rtl/pmem_line_array.sv
// Line storage: 2^LINE_BITS lines of 128 bits.
//   clk, reset : clock; reset clears only the read register, never the array
//   we         : write wdata into line `index` on the rising edge
//   re         : load line `index` into the read register on the rising edge
//   index      : line index shared by both ports
//   wdata      : line to write
//   rdata      : registered read data, holds its value when re is low
module pmem_line_array
    import lc3b_types::*;
#(
    parameter int LINE_BITS = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic                 re,
    input  logic [LINE_BITS-1:0] index,
    input  lc3b_line             wdata,
    output lc3b_line             rdata
);

    lc3b_line mem [2**LINE_BITS];

    // No reset on the array so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/pmem_responder.sv
// Line-granular physical memory responder with fixed response latency.
//   DELAY     : cycles from request acceptance to pmem_resp (1..15)
//   LINE_BITS : line-index width; address bits [LINE_BITS+3:4] select the line
//   clk       : clock
//   reset     : synchronous active-high reset
//   mem_if    : slave side of the memory port (see pmem_responder_if)
//   dbg_state : current FSM state (0 IDLE, 1 BUSY, 2 RESP)
module pmem_responder
    import lc3b_types::*;
#(
    parameter int DELAY     = 4,
    parameter int LINE_BITS = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    pmem_responder_if.slave         mem_if,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // The IDLE->BUSY edge and the BUSY->RESP edge each take one cycle, so the
    // countdown covers the remaining DELAY-2 cycles.
    localparam int         LOAD_INT = (DELAY > 1) ? DELAY - 2 : 0;
    localparam logic [3:0] CNT_LOAD = 4'(LOAD_INT);

    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 op_write_q, op_write_d;
    logic [LINE_BITS-1:0] index_q, index_d;

    logic                 req;
    logic [LINE_BITS-1:0] req_index;
    logic                 mem_we;
    logic                 mem_re;
    logic                 entering_resp;

    // Byte enables and the offset/high address bits have no effect.
    logic unused_bits;
    assign unused_bits = ^{mem_if.pmem_byte_enable, mem_if.pmem_address};

    assign req       = mem_if.pmem_read | mem_if.pmem_write;
    assign req_index = mem_if.pmem_address[LINE_BITS+3:4];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_write_q <= 1'b0;
            index_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_write_q <= op_write_d;
            index_q    <= index_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        index_d    = index_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    op_write_d = mem_if.pmem_write;
                    index_d    = req_index;
                    cnt_d      = CNT_LOAD;
                    state_d    = (DELAY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs. The storage access happens on the edge that enters RESP, using the
    // operation/index being latched on that edge (which covers DELAY=1, where the
    // request is accepted and completed on the same edge).
    always_comb begin
        entering_resp    = (state_d == RESP) && (state_q != RESP);
        mem_we           = entering_resp && op_write_d && !reset;
        mem_re           = entering_resp && !op_write_d && !reset;
        mem_if.pmem_resp = (state_q == RESP);
        dbg_state        = state_q;
    end

    pmem_line_array #(
        .LINE_BITS (LINE_BITS)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .re    (mem_re),
        .index (index_d),
        .wdata (mem_if.pmem_wdata),
        .rdata (mem_if.pmem_rdata)
    );

endmodule

// File: tb/tb_pmem_responder.sv
module tb_pmem_responder;
    import lc3b_types::*;

    localparam lc3b_line D0 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam lc3b_line D1 = 128'hDEADBEEF0000000011111111CAFEF00D;
    localparam lc3b_line D2 = 128'hBAD0BAD0BAD0BAD0BAD0BAD0BAD0BAD0;
    localparam lc3b_line D3 = 128'h00000040AAAA5555AAAA555500000040;
    localparam lc3b_line D4 = 128'h11112222333344445555666677778888;
    localparam lc3b_line D5 = 128'h99990000AAAABBBBCCCCDDDDEEEEFFFF;
    localparam lc3b_line D6 = 128'h5A5A5A5AA5A5A5A50F0F0F0FF0F0F0F0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] st0, st1, st2;

    pmem_responder_if if0();
    pmem_responder_if if1();
    pmem_responder_if if2();

    pmem_responder #(.DELAY(4), .LINE_BITS(12)) u0 (
        .clk(clk), .reset(reset), .mem_if(if0), .dbg_state(st0));
    pmem_responder #(.DELAY(1), .LINE_BITS(12)) u1 (
        .clk(clk), .reset(reset), .mem_if(if1), .dbg_state(st1));
    pmem_responder #(.DELAY(4), .LINE_BITS(4)) u2 (
        .clk(clk), .reset(reset), .mem_if(if2), .dbg_state(st2));

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    lc3b_line exp_q[$];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input bit rd, input bit wr,
                         input lc3b_word addr, input lc3b_line wdata);
        case (sel)
            0: begin
                if0.pmem_read = rd; if0.pmem_write = wr;
                if0.pmem_address = addr; if0.pmem_wdata = wdata;
            end
            1: begin
                if1.pmem_read = rd; if1.pmem_write = wr;
                if1.pmem_address = addr; if1.pmem_wdata = wdata;
            end
            default: begin
                if2.pmem_read = rd; if2.pmem_write = wr;
                if2.pmem_address = addr; if2.pmem_wdata = wdata;
            end
        endcase
    endtask

    function automatic logic get_resp(input int sel);
        case (sel)
            0:       return if0.pmem_resp;
            1:       return if1.pmem_resp;
            default: return if2.pmem_resp;
        endcase
    endfunction

    function automatic lc3b_line get_rdata(input int sel);
        case (sel)
            0:       return if0.pmem_rdata;
            1:       return if1.pmem_rdata;
            default: return if2.pmem_rdata;
        endcase
    endfunction

    // Issue one request in cycle T, hold it until pmem_resp is seen, then drop it.
    // cyc returns k for a response in cycle T+k, or -1 if none within the budget.
    task automatic access(input int sel, input bit rd, input bit wr, input lc3b_word addr,
                          input lc3b_line wdata, output int cyc, output lc3b_line data);
        cyc  = -1;
        data = '0;
        @(posedge clk); #1;
        drive(sel, rd, wr, addr, wdata);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (get_resp(sel)) begin
                cyc  = k;
                data = get_rdata(sel);
                break;
            end
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, addr, wdata);
    endtask

    // ---------------- stimulus ----------------
    int       cyc;
    lc3b_line data;
    int       n_resp;
    int       pulse_cyc[2];

    initial begin
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0);
        if0.pmem_byte_enable = 2'b11;
        if1.pmem_byte_enable = 2'b11;
        if2.pmem_byte_enable = 2'b11;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp0",  128'(if0.pmem_resp), 128'(0));
        check("rst_rdata0", if0.pmem_rdata, 128'h0);
        check("rst_state0", 128'(st0), 128'(0));
        check("rst_resp1",  128'(if1.pmem_resp), 128'(0));
        check("rst_rdata2", if2.pmem_rdata, 128'h0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Write 0x0A0 with DELAY=4: response in T+4, one cycle wide
        access(0, 1'b0, 1'b1, 16'h0A00, D0, cyc, data);
        check("wr_latency", 128'(cyc), 128'(4));
        @(negedge clk);
        check("wr_resp_width", 128'(if0.pmem_resp), 128'(0));
        check("wr_keeps_rdata", if0.pmem_rdata, 128'h0);

        // Read back through a different offset in the same line
        access(0, 1'b1, 1'b0, 16'h0A0F, '0, cyc, data);
        check("rd_latency", 128'(cyc), 128'(4));
        check("rd_data_0a0", data, D0);

        // Put D1 in 0x123 and leave it in pmem_rdata
        access(0, 1'b0, 1'b1, 16'h1230, D1, cyc, data);
        check("wr123_latency", 128'(cyc), 128'(4));
        access(0, 1'b1, 1'b0, 16'h1230, '0, cyc, data);
        check("rd_data_123", data, D1);

        // Read of 0x0A00 dropped in cycle T+2
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 16'h0A00, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 16'h0A00, '0);
        n_resp = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if0.pmem_resp) n_resp++;
        end
        check("drop_no_resp", 128'(n_resp), 128'(0));
        check("drop_state_idle", 128'(st0), 128'(0));
        check("drop_rdata_kept", if0.pmem_rdata, D1);

        // Write of D2 to 0x1230 aborted by reset in cycle T+2
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 16'h1230, D2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 16'h1230, D2);
        @(negedge clk);
        check("abort_resp", 128'(if0.pmem_resp), 128'(0));
        check("abort_rdata", if0.pmem_rdata, 128'h0);
        check("abort_state", 128'(st0), 128'(0));
        n_resp = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (if0.pmem_resp) n_resp++;
        end
        check("abort_no_resp", 128'(n_resp), 128'(0));
        access(0, 1'b1, 1'b0, 16'h1230, '0, cyc, data);
        check("abort_old_data", data, D1);

        // Read and write both high: a write, pmem_rdata untouched
        access(0, 1'b1, 1'b1, 16'h0040, D3, cyc, data);
        check("both_latency", 128'(cyc), 128'(4));
        check("both_rdata_kept", data, D1);
        access(0, 1'b1, 1'b0, 16'h0040, '0, cyc, data);
        check("both_stored", data, D3);

        // DELAY=1: fill two lines, then back-to-back reads
        access(1, 1'b0, 1'b1, 16'h0100, D4, cyc, data);
        check("d1_wr_latency", 128'(cyc), 128'(1));
        access(1, 1'b0, 1'b1, 16'h0200, D5, cyc, data);
        check("d1_wr2_latency", 128'(cyc), 128'(1));
        exp_q.push_back(D4);
        exp_q.push_back(D5);
        pulse_cyc[0] = -1;
        pulse_cyc[1] = -1;
        n_resp = 0;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 16'h0100, '0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (if1.pmem_resp) begin
                if (n_resp < 2) pulse_cyc[n_resp] = k;
                n_resp++;
                if (exp_q.size() > 0) begin
                    check("b2b_rdata", if1.pmem_rdata, exp_q.pop_front());
                end else begin
                    check("b2b_extra_resp", 128'(k), 128'(-1));
                end
                @(posedge clk); #1;
                if (n_resp == 1) drive(1, 1'b1, 1'b0, 16'h0200, '0);
                else             drive(1, 1'b0, 1'b0, 16'h0200, '0);
            end
        end
        check("b2b_first_cyc", 128'(pulse_cyc[0]), 128'(1));
        check("b2b_second_cyc", 128'(pulse_cyc[1]), 128'(3));
        check("b2b_count", 128'(n_resp), 128'(2));

        // LINE_BITS=4: 0x0110 aliases line 1 with 0x0010
        access(2, 1'b0, 1'b1, 16'h0010, D6, cyc, data);
        check("wrap_wr_latency", 128'(cyc), 128'(4));
        access(2, 1'b1, 1'b0, 16'h0110, '0, cyc, data);
        check("wrap_rd_data", data, D6);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
